// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one word-addressed memory bus between two requesters.
//   - Round-robin grant, with one transaction in flight at a time.
//   - The memory side uses a ready handshake with variable latency.
//   - A timeout counter aborts accesses that never see mem_ready.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   mN_req/we/addr/wdata      requester N transaction (held until mN_ack)
//   mN_rdata/ack/err          requester N completion (registered)
//   mem_re/mem_we             memory read / write strobes (registered)
//   memaddr/mem_wdata         memory address / write data (registered)
//   mem_rdata/mem_ready       memory read data / access completion
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_err,
  // requester 1
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_err,
  // memory side
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] memaddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  // TIMEOUT is limited to 1..255, so an 8-bit busy counter is enough.
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                mem_re_q, mem_re_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   memaddr_q, memaddr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic                m0_ack_q, m0_ack_d;
  logic                m1_ack_q, m1_ack_d;
  logic                m0_err_q, m0_err_d;
  logic                m1_err_q, m1_err_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Arbitration and per-transaction helpers.
  logic                win_c;
  logic                win_we_c;
  logic [DATA_W-1:0]   done_rdata_c;
  logic                done_err_c;
  logic                finish_c;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      memaddr_q    <= '0;
      mem_wdata_q  <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      memaddr_q    <= memaddr_d;
      mem_wdata_q  <= mem_wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_err_q     <= m0_err_d;
      m1_err_q     <= m1_err_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    mem_re_d     = mem_re_q;
    mem_we_d     = mem_we_q;
    memaddr_d    = memaddr_q;
    mem_wdata_d  = mem_wdata_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    m0_ack_d     = m0_ack_q;
    m1_ack_d     = m1_ack_q;
    m0_err_d     = m0_err_q;
    m1_err_d     = m1_err_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;

    // On a tie the requester that was not served last wins.
    // Otherwise the single active requester wins.
    win_c        = (m0_req && m1_req) ? ~last_grant_q : m1_req;
    win_we_c     = win_c ? m1_we : m0_we;
    done_rdata_c = '0;
    done_err_c   = 1'b0;
    finish_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          memaddr_d   = win_c ? m1_addr  : m0_addr;
          mem_wdata_d = win_c ? m1_wdata : m0_wdata;
          mem_re_d    = ~win_we_c;
          mem_we_d    = win_we_c;
          owner_d     = win_c;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end

      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A ready in the last allowed cycle still counts as a normal completion.
        if (mem_ready) begin
          finish_c     = 1'b1;
          done_rdata_c = mem_rdata;
          done_err_c   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          finish_c     = 1'b1;
          done_rdata_c = '1;
          done_err_c   = 1'b1;
        end

        if (finish_c) begin
          mem_re_d     = 1'b0;
          mem_we_d     = 1'b0;
          last_grant_d = owner_q;
          state_d      = DONE;
          // Only the owner's completion signals change.
          // Its rdata is left alone on a write.
          if (owner_q) begin
            m1_ack_d = 1'b1;
            m1_err_d = done_err_c;
            if (mem_re_q) m1_rdata_d = done_rdata_c;
          end else begin
            m0_ack_d = 1'b1;
            m0_err_d = done_err_c;
            if (mem_re_q) m0_rdata_d = done_rdata_c;
          end
        end
      end

      DONE: begin
        // Requests are not sampled here.
        // The owner may drop or change its req during its ack cycle.
        m0_ack_d = 1'b0;
        m1_ack_d = 1'b0;
        m0_err_d = 1'b0;
        m1_err_d = 1'b0;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign memaddr   = memaddr_q;
  assign mem_wdata = mem_wdata_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter sharing the single CPU memory bus (mem_re/mem_we/memaddr, 30-bit word address, 32-bit data) between two requesters, e.g. cpu instruction/data port and a debug/DMA port.
- Round-robin grant; one transaction in flight at a time.
- Memory side uses a ready handshake with variable latency; a timeout counter aborts hung accesses.
- Sits between the requesters and the memory model/controller; split read/write data buses (no tristate inside the block).

Parameters:
ADDR_W, 30, word address width
DATA_W, 32, data width
TIMEOUT, 15, max BUSY cycles waiting for mem_ready before abort (1..255)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
m0_req  in  1  requester 0 transaction request, held until m0_ack
m0_we  in  1  1 = write, 0 = read
m0_addr  in  ADDR_W  word address
m0_wdata  in  DATA_W  write data
m0_rdata  out  DATA_W  registered read data, valid while m0_ack high
m0_ack  out  1  one-cycle completion pulse
m0_err  out  1  qualifies m0_ack: transaction timed out
m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err: same as m0 for requester 1
mem_re  out  1  memory read strobe
mem_we  out  1  memory write strobe
memaddr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completes current access

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; mem_re, mem_we, m0_ack, m1_ack, m0_err, m1_err = 0; memaddr, mem_wdata, m0_rdata, m1_rdata = 0; owner = 0; last_grant = 1, so m0 wins the first tie; timeout count = 0.
- All outputs are registered.

State machine: IDLE -> BUSY -> DONE -> IDLE.
- IDLE, no req: stay in IDLE, strobes low.
- IDLE, one req: grant that requester.
- IDLE, both req: grant the requester that is not last_grant.
- IDLE, on grant:
  - Register memaddr/mem_wdata from the winner.
  - Set mem_re = !we and mem_we = we.
  - Set owner = winner, clear count, go to BUSY.
- BUSY:
  - Strobes and address are held stable; count increments each cycle.
  - mem_ready = 1: drop strobes.
    - If read: latch mem_rdata into owner's rdata.
    - Set owner's ack = 1, err = 0, last_grant = owner, go to DONE.
  - mem_ready = 0 and count == TIMEOUT-1: abort.
    - Drop strobes.
    - If read: owner's rdata = all ones.
    - Set owner's ack = 1, err = 1, last_grant = owner, go to DONE.
  - mem_ready and timeout in the same cycle: mem_ready wins (normal completion).
- DONE:
  - ack/err are high this cycle only; cleared on exit. Go to IDLE.
  - Requests are not sampled in DONE. This lets the owner drop or change req/fields during its ack cycle without a stale re-grant.
- Write completion leaves rdata unchanged. The non-owner's rdata/ack/err are never modified.
- Latency: req seen in IDLE at cycle N gives strobes at N+1; ack at cycle R+1, where R is the cycle mem_ready is sampled high in BUSY. Minimum is 3 cycles per transaction (mem_ready high in the first BUSY cycle). Back-to-back throughput is one transaction per 3 cycles.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1.
- mem_ready while in IDLE or DONE: ignored.
- Requester field changes while its request is in flight: ignored; values were captured at grant.
- req dropped before ack: the transaction still completes and acks. This is a requester protocol violation, not checked.
- Reset asserted mid-BUSY: at the next edge all outputs return to reset values; the in-flight access is abandoned with no ack. Memory must tolerate strobe removal.

Test Plan:
- Single read: m0_req=1, m0_we=0, m0_addr=0x0000010; mem_ready high 2 cycles after mem_re; mem_rdata=0xDEADBEEF -> memaddr=0x10, mem_re=1 for 2 cycles; m0_ack pulse one cycle later with m0_rdata=0xDEADBEEF, m0_err=0.
- Single write from m1: addr 0x3FFFFFFF, wdata 0x12345678, mem_ready in first BUSY cycle -> mem_we=1 one cycle, mem_wdata=0x12345678, m1_ack at cycle 2, m1_rdata unchanged (0).
- Contention: both req held high from reset release for 4 transactions -> grant order m0, m1, m0, m1; acks every 3 cycles; no ack to the non-owner.
- Timeout: m0 read, mem_ready never asserted, TIMEOUT=15 -> mem_re high exactly 15 cycles; m0_ack=1, m0_err=1, m0_rdata=0xFFFFFFFF.
- Edge at timeout: mem_ready asserted on the 15th BUSY cycle -> normal completion, err=0, real data returned.
- Reset mid-BUSY: rst=1 during the 2nd BUSY cycle -> next edge mem_re=0, no ack; after release, a pending m1 and m0 pair is granted to m0 first (last_grant reset to 1).
